// File: rtl/comb_filter_ctrl.sv
// Comb-filter sequencer: settings decode, flush-then-prime on enable/reconfig; optional status port via COMB_CTRL_STATUS_EN.
// Latency: settings write visible one clock later; strobe_out and PRIME/RUN comb_ce lag strobe_in by one clock.
// Backpressure: none; every settings write and input strobe is accepted.
module comb_filter_ctrl #(
    parameter logic [6:0] SR_ADDR    = 7'd0,
    parameter int         DELAY_LOG2 = 3,
    parameter int         SETTLE_W   = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_serial_strobe,
    input  logic [6:0]  i_serial_addr,
    input  logic [31:0] i_serial_data,
    input  logic        i_strobe_in,
    output logic        o_comb_clear,
    output logic        o_comb_ce,
    output logic        o_out_sel,
    output logic        o_strobe_out,
    output logic        o_ready
`ifdef COMB_CTRL_STATUS_EN
    ,
    output logic [31:0] o_status
`endif
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_FLUSH = 2'd1,
        S_PRIME = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [6:0]            SETTLE_ADDR = SR_ADDR + 7'd1;
    localparam logic [DELAY_LOG2-1:0] FLUSH_LAST  = '1;
    localparam logic [DELAY_LOG2-1:0] FLUSH_ONE   = {{(DELAY_LOG2-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_enable;
    logic                  r_bypass;
    logic [SETTLE_W-1:0]   r_settle;
    logic [SETTLE_W-1:0]   r_settle_cnt;
    logic [DELAY_LOG2-1:0] r_flush_cnt;
    logic                  r_strobe_d;

    logic                  w_ctrl_wr;
    logic                  w_settle_wr;
    logic                  w_enable_wr;
    logic                  w_disable_wr;
    logic                  w_force_flush;
    logic [SETTLE_W:0]     w_settle_inc;
    logic                  w_prime_done;
    logic                  w_unused;

    assign w_ctrl_wr     = i_serial_strobe && (i_serial_addr == SR_ADDR);
    assign w_settle_wr   = i_serial_strobe && (i_serial_addr == SETTLE_ADDR);
    assign w_enable_wr   = w_ctrl_wr &&  i_serial_data[0];
    assign w_disable_wr  = w_ctrl_wr && !i_serial_data[0];
    // A settle write reconfigures the filter, so it restarts history just like an explicit flush.
    assign w_force_flush = (w_enable_wr && i_serial_data[2]) || (w_settle_wr && r_enable);
    assign w_settle_inc  = {1'b0, r_settle_cnt} + {{SETTLE_W{1'b0}}, 1'b1};
    assign w_prime_done  = i_strobe_in && (w_settle_inc == {1'b0, r_settle});
    assign w_unused      = &{1'b0, i_serial_data[31:SETTLE_W]};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Disable beats every other event, then a forced flush beats normal progress.
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_OFF) begin
            if (w_enable_wr) w_state_next = S_FLUSH;
        end else if (w_disable_wr) begin
            w_state_next = S_OFF;
        end else if (w_force_flush) begin
            w_state_next = S_FLUSH;
        end else begin
            case (r_state)
                S_FLUSH: if (r_flush_cnt == FLUSH_LAST)
                             w_state_next = (r_settle == '0) ? S_RUN : S_PRIME;
                S_PRIME: if (w_prime_done) w_state_next = S_RUN;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        o_comb_clear = 1'b0;
        o_comb_ce    = 1'b0;
        o_out_sel    = 1'b0;
        o_ready      = 1'b0;
        case (r_state)
            S_OFF:   o_comb_clear = 1'b1;
            S_FLUSH: begin
                o_comb_clear = 1'b1;
                o_comb_ce    = 1'b1;
            end
            S_PRIME: o_comb_ce = r_strobe_d;
            S_RUN: begin
                o_comb_ce = r_strobe_d;
                o_out_sel = ~r_bypass;
                o_ready   = 1'b1;
            end
            default: o_comb_clear = 1'b1;
        endcase
    end

    assign o_strobe_out = r_strobe_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_enable     <= 1'b0;
            r_bypass     <= 1'b0;
            r_settle     <= '0;
            r_settle_cnt <= '0;
            r_flush_cnt  <= '0;
            r_strobe_d   <= 1'b0;
        end else begin
            r_strobe_d <= i_strobe_in;
            if (w_ctrl_wr) begin
                r_enable <= i_serial_data[0];
                r_bypass <= i_serial_data[1];
            end
            if (w_settle_wr) r_settle <= i_serial_data[SETTLE_W-1:0];
            // Counter restarts on entry to FLUSH and on a re-forced flush while already flushing.
            if (r_state == S_FLUSH && w_state_next == S_FLUSH && !w_force_flush)
                r_flush_cnt <= r_flush_cnt + FLUSH_ONE;
            else
                r_flush_cnt <= '0;
            if (w_state_next == S_FLUSH || w_state_next == S_OFF)
                r_settle_cnt <= '0;
            else if (r_state == S_PRIME && i_strobe_in)
                r_settle_cnt <= w_settle_inc[SETTLE_W-1:0];
        end
    end

`ifdef COMB_CTRL_STATUS_EN
    logic [7:0] r_flush_done;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_flush_done <= '0;
        end else if (r_state == S_FLUSH && (w_state_next == S_PRIME || w_state_next == S_RUN)
                     && r_flush_done != 8'hFF) begin
            r_flush_done <= r_flush_done + 8'd1;
        end
    end

    assign o_status = {16'(r_settle_cnt), r_flush_done, 5'b0, r_bypass, r_state};
`endif

endmodule

// File: doc/comb_filter_ctrl.md
# comb_filter_ctrl

Sequencer and configuration front-end for the receive-path comb filter. Decodes settings-bus writes, controls the filter's clear and clock-enable, and runs a flush-then-prime sequence on every enable or reconfiguration, so downstream logic never sees stale history. It sits between the settings bus and one I/Q comb-filter datapath and drives that datapath's output mux.

## Interface
- SR_ADDR, 7'd0: base settings address; control register at SR_ADDR, settle register at SR_ADDR+1.
- DELAY_LOG2, 3: comb delay depth log2; flush length is 2^DELAY_LOG2 clocks.
- SETTLE_W, 16: width of the settle sample counter.

- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and registers.
- serial_strobe  in  1  settings write strobe, one clock per write.
- serial_addr  in  7  settings address.
- serial_data  in  32  settings data.
- strobe_in  in  1  input sample strobe from upstream decimator.
- comb_clear  out  1  synchronous clear to comb datapath.
- comb_ce  out  1  datapath advance enable.
- out_sel  out  1  0 = raw/bypass path, 1 = filtered path.
- strobe_out  out  1  output sample strobe, delayed by one clock from strobe_in.
- ready  out  1  high only in RUN.

## Operation
- Control register (SR_ADDR): bit0 enable, bit1 bypass, bit2 flush (self-clearing pulse, not stored). Settle register (SR_ADDR+1): bits[SETTLE_W-1:0] = number of input samples to prime.
- Writes to any other address are ignored. Register reset values are 0.
- The state register is 2 bits wide with four states:
  - OFF: comb_clear=1, comb_ce=0, out_sel=0.
  - FLUSH: comb_clear=1, comb_ce=1. A flush counter runs 0..2^DELAY_LOG2-1 to walk every history slot.
  - PRIME: comb_clear=0, comb_ce=strobe_in, out_sel=0. The settle counter increments on each strobe_in.
  - RUN: comb_clear=0, comb_ce=strobe_in, out_sel=~bypass, ready=1.
- Transitions:
  - OFF→FLUSH when enable is written 1.
  - FLUSH→PRIME when the flush counter equals 2^DELAY_LOG2-1.
  - PRIME→RUN when settle count+1 equals the settle value on a strobe_in clock. If the settle value is 0, FLUSH→RUN directly.
  - Any state→OFF when enable is written 0.
  - PRIME or RUN→FLUSH on a write with flush=1 and enable=1, or on any write to the settle register while enable=1.
- Simultaneous events:
  - Disable beats flush.
  - A write that forces FLUSH while in FLUSH restarts the flush counter at 0.
  - strobe_in during OFF or FLUSH is not counted, and strobe_out still follows strobe_in.
- Changing bypass in RUN updates out_sel on the next clock without flushing.
- Settle counter width is SETTLE_W. A settle value of all ones primes for 2^SETTLE_W-1 samples. Counters do not wrap within a state.

## Timing
- Settings writes are captured on the clock where serial_strobe=1. The new state and outputs are visible on the following clock (1-cycle latency).
- All outputs are registered. Exception: comb_ce in PRIME and RUN equals the registered state AND strobe_in delayed one clock, aligned with strobe_out.
- Flush occupies exactly 2^DELAY_LOG2 clocks of comb_clear=1 (8 with defaults).
- Reset values: comb_clear=1, comb_ce=0, out_sel=0, strobe_out=0, ready=0, state=OFF.
- Reset asserted mid-FLUSH or mid-PRIME returns to OFF immediately. After release the block stays in OFF until enable is written again.

## Configuration
- COMB_CTRL_STATUS_EN defined: adds output status [31:0]. Fields:
  - [1:0] state.
  - [2] bypass.
  - [15:8] count of completed flushes, saturating at 255.
  - [31:16] current settle counter.
- All status fields are registered and reset to 0.
- COMB_CTRL_STATUS_EN undefined: the port and its counters are absent. All other behaviour is identical.

## Test plan
- Reset, then idle 10 clocks → comb_clear=1, comb_ce=0, ready=0, out_sel=0 throughout.
- Write settle=4, then control=0x1, with strobe_in every 2nd clock → comb_clear high 8 clocks. After 4 counted strobes, ready=1 and out_sel=1.
- In RUN, write control=0x3 → next clock out_sel=0, ready stays 1, no flush.
- In RUN, write control=0x5 → FLUSH for 8 clocks, then PRIME for 4 samples, then RUN. Repeat the write mid-FLUSH → flush counter restarts and total clear time is extended.
- Write settle=0 with enable=1 → FLUSH 8 clocks, then directly RUN. Then write control=0x4 (flush with enable=0) → OFF on next clock.
- Assert reset during PRIME → outputs go to reset values asynchronously. Release → stays OFF, and strobe_in still produces strobe_out one clock later.
